// File: rtl/bbox_msg_reader_if.sv
// Bus bundle for bbox_msg_reader: Avalon-MM master signals toward the image
// processor slave port, plus the decoded-box valid/ready output channel.
interface bbox_msg_reader_if;
    logic        m_chipselect;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    logic        bb_valid;
    logic        bb_ready;
    logic [10:0] bb_left;
    logic [10:0] bb_top;
    logic [10:0] bb_right;
    logic [10:0] bb_bottom;
    logic        bb_none;

    modport master (
        output m_chipselect, m_read, m_write, m_address, m_writedata,
        input  m_readdata,
        output bb_valid, bb_left, bb_top, bb_right, bb_bottom, bb_none,
        input  bb_ready
    );

    modport slave (
        input  m_chipselect, m_read, m_write, m_address, m_writedata,
        output m_readdata,
        input  bb_valid, bb_left, bb_top, bb_right, bb_bottom, bb_none,
        output bb_ready
    );
endinterface

// File: rtl/bbox_msg_reader.sv
// Avalon-MM master that drains the image processor's bounding-box message
// FIFO: polls status, pops 3-word RBB messages, checks framing, and presents
// decoded box edges on a valid/ready channel.
module bbox_msg_reader #(
    parameter int unsigned POLL_INTERVAL = 64,
    parameter logic [31:0] MSG_ID        = 32'h00524242,
    parameter int unsigned IMAGE_W       = 640,
    parameter int unsigned IMAGE_H       = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    bbox_msg_reader_if.master        bus,
    output logic                     overrun,
    output logic [7:0]               resync_count
);

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_MSG    = 3'd1;
    localparam logic [31:0] FLUSH_CMD   = 32'h0000_0010;
    localparam int unsigned CW          = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(POLL_INTERVAL - 1);
    // Sentinel edges the writer uses when nothing was detected.
    localparam logic [10:0] NONE_LEFT   = 11'(IMAGE_W - 1);
    localparam logic [10:0] NONE_TOP    = 11'(IMAGE_H - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FLUSH,
        S_POLL,
        S_POLL_CHK,
        S_WAIT,
        S_RD_HDR,
        S_HDR_CHK,
        S_RD_TL,
        S_TL_CHK,
        S_RD_BR,
        S_BR_CHK,
        S_PUBLISH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          flush_pending;
    logic [10:0]   tl_x;
    logic [10:0]   tl_y;

    logic [7:0]    status_n;
    logic          word_ok;
    logic [10:0]   word_x;
    logic [10:0]   word_y;
    logic          new_none;

    logic          cs;
    logic          rd;
    logic          wr;
    logic [2:0]    addr;
    logic [31:0]   wdata;
    logic          hdr_bad;
    logic          edge_bad;
    logic          tl_load;
    logic          publish_now;

    logic          box_valid;
    logic [10:0]   box_left;
    logic [10:0]   box_top;
    logic [10:0]   box_right;
    logic [10:0]   box_bottom;
    logic          box_none;
    logic          ovr;
    logic [7:0]    resync;

    assign status_n = bus.m_readdata[15:8];
    assign word_x   = bus.m_readdata[26:16];
    assign word_y   = bus.m_readdata[10:0];
    assign word_ok  = (bus.m_readdata[31:27] == '0) && (bus.m_readdata[15:11] == '0);
    // Sentinel terms are subsumed by the ordering tests; kept so the
    // no-detection encoding is visible alongside the general rule.
    assign new_none = (tl_x > word_x) || (tl_y > word_y) ||
                      ((tl_x == NONE_LEFT) && (word_x == '0)) ||
                      ((tl_y == NONE_TOP) && (word_y == '0));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; only POLL_CHK and WAIT honour a dropped enable so an
    // in-flight message always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = flush_pending ? S_FLUSH : S_POLL;
                end
            end
            S_FLUSH:    state_nxt = S_POLL;
            S_POLL:     state_nxt = S_POLL_CHK;
            S_POLL_CHK: begin
                if (status_n >= 8'd3) begin
                    state_nxt = S_RD_HDR;
                end else if (!enable) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_POLL;
                end
            end
            S_RD_HDR:   state_nxt = S_HDR_CHK;
            S_HDR_CHK:  state_nxt = (bus.m_readdata == MSG_ID) ? S_RD_TL : S_POLL;
            S_RD_TL:    state_nxt = S_TL_CHK;
            S_TL_CHK:   state_nxt = word_ok ? S_RD_BR : S_POLL;
            S_RD_BR:    state_nxt = S_BR_CHK;
            S_BR_CHK:   state_nxt = word_ok ? S_PUBLISH : S_POLL;
            S_PUBLISH:  state_nxt = enable ? S_POLL : S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Bus strobes and datapath controls decoded from the current state.
    always_comb begin
        cs          = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        addr        = '0;
        wdata       = '0;
        hdr_bad     = 1'b0;
        edge_bad    = 1'b0;
        tl_load     = 1'b0;
        publish_now = 1'b0;
        case (state)
            S_FLUSH: begin
                cs    = 1'b1;
                wr    = 1'b1;
                addr  = ADDR_STATUS;
                wdata = FLUSH_CMD;
            end
            S_POLL: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = ADDR_STATUS;
            end
            S_RD_HDR, S_RD_TL, S_RD_BR: begin
                cs   = 1'b1;
                rd   = 1'b1;
                addr = ADDR_MSG;
            end
            S_HDR_CHK: hdr_bad = (bus.m_readdata != MSG_ID);
            S_TL_CHK: begin
                tl_load  = word_ok;
                edge_bad = !word_ok;
            end
            // The box registers load on the edge into PUBLISH so bb_valid
            // rises during the PUBLISH cycle itself.
            S_BR_CHK: begin
                publish_now = word_ok;
                edge_bad    = !word_ok;
            end
            default: ;
        endcase
    end

    // Poll back-off counter, restarted whenever WAIT is entered.
    always_ff @(posedge clk) begin
        if (reset || (state != S_WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A reset can strand a partial message in the slave; flush before polling.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pending <= 1'b1;
        end else if (state == S_FLUSH) begin
            flush_pending <= 1'b0;
        end
    end

    // Hold the top-left corner until the bottom-right word arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            tl_x <= '0;
            tl_y <= '0;
        end else if (tl_load) begin
            tl_x <= word_x;
            tl_y <= word_y;
        end
    end

    // Saturating count of framing errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            resync <= '0;
        end else if ((hdr_bad || edge_bad) && (resync != 8'hFF)) begin
            resync <= resync + 8'd1;
        end
    end

    // Output box register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            box_valid  <= 1'b0;
            box_left   <= '0;
            box_top    <= '0;
            box_right  <= '0;
            box_bottom <= '0;
            box_none   <= 1'b0;
            ovr        <= 1'b0;
        end else if (publish_now) begin
            box_valid  <= 1'b1;
            box_left   <= tl_x;
            box_top    <= tl_y;
            box_right  <= word_x;
            box_bottom <= word_y;
            box_none   <= new_none;
            if (box_valid && !bus.bb_ready) begin
                ovr <= 1'b1;
            end
        end else if (box_valid && bus.bb_ready) begin
            box_valid <= 1'b0;
        end
    end

    assign bus.m_chipselect = cs;
    assign bus.m_read       = rd;
    assign bus.m_write      = wr;
    assign bus.m_address    = addr;
    assign bus.m_writedata  = wdata;
    assign bus.bb_valid     = box_valid;
    assign bus.bb_left      = box_left;
    assign bus.bb_top       = box_top;
    assign bus.bb_right     = box_right;
    assign bus.bb_bottom    = box_bottom;
    assign bus.bb_none      = box_none;
    assign overrun          = ovr;
    assign resync_count     = resync;

endmodule

// File: doc/bbox_msg_reader.md
Name: bbox_msg_reader

Overview:
- Avalon-MM master that drains the bounding-box message FIFO of the image processor's memory-mapped slave port.
- Replaces CPU polling of that port with hardware.
- Polls the status register, pops 3-word "RBB" messages, checks their framing, and presents decoded box edges on a valid/ready output for downstream steering logic.
- Sits beside the image processor on the same clock and connects directly to its slave port.

Parameters:
- POLL_INTERVAL, 64: idle cycles between status polls when fewer than 3 words are queued.
- MSG_ID, 32'h00524242: expected header word ("RBB").
- IMAGE_W, 640: width used for no-detection decode.
- IMAGE_H, 480: height used for no-detection decode.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- m_chipselect  out  1  slave select.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_address  out  3  word address: 0 = status, 1 = message.
- m_writedata  out  32  write data.
- m_readdata  in  32  slave read data; fixed latency 1.
- bb_valid  out  1  decoded box available.
- bb_ready  in  1  consumer accepts box.
- bb_left  out  11  box left edge.
- bb_top  out  11  box top edge.
- bb_right  out  11  box right edge.
- bb_bottom  out  11  box bottom edge.
- bb_none  out  1  no red pixels detected in that frame.
- overrun  out  1  sticky: an unconsumed box was overwritten.
- resync_count  out  8  framing errors seen; saturates at 255.

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE, and the flush_pending flag is set.
- Bus access rules:
  - A read is m_chipselect=m_read=1 for exactly one cycle. m_readdata is sampled on the following cycle.
  - m_read is never high on two consecutive cycles, because the slave pops only on the rising edge of read. Minimum read cost is therefore 2 cycles.
  - m_write is a one-cycle strobe. m_chipselect is high only during a strobe.
- FSM states:
  - IDLE: if enable and flush_pending, go to FLUSH. Else if enable, go to POLL.
  - FLUSH: write 32'h10 to address 0 (flushes stale or partial messages). Clear flush_pending, then go to POLL.
  - POLL: read address 0 and go to POLL_CHK.
  - POLL_CHK: n = m_readdata[15:8]. If n>=3, go to RD_HDR. Otherwise, if enable is low, go to IDLE. Otherwise go to WAIT.
  - WAIT: count POLL_INTERVAL cycles, then go to POLL. If enable drops, go to IDLE.
  - RD_HDR: read address 1, then check the word. If it equals MSG_ID, go to RD_TL. Otherwise increment resync_count and go to POLL. Each failed header pops one word, so a misaligned stream realigns word by word.
  - RD_TL: read address 1. x = word[26:16], y = word[10:0].
  - RD_BR: read address 1, decoded the same way.
  - A TL or BR word with nonzero bits [31:27] or [15:11] is malformed: increment resync_count, discard the message, go to POLL.
  - After a good BR word: go to PUBLISH.
  - PUBLISH (1 cycle): load bb_* registers and set bb_valid. Then go to POLL if enable, else IDLE.
- enable deasserted mid-message: the current message completes first. Only the POLL_CHK and WAIT exits honour enable.
- No-detection decode: bb_none = (left > right) | (top > bottom). The writer sends left=IMAGE_W-1 and right=0 when nothing is detected; edges are still passed through raw.
- Output handshake:
  - bb_valid stays high until the cycle where bb_valid & bb_ready; it clears on the next edge.
  - bb_* fields are stable while bb_valid is high, except on overwrite.
  - Overwrite: PUBLISH while bb_valid=1 and bb_ready=0 overwrites the fields, keeps bb_valid=1, and sets overrun.
  - PUBLISH in the same cycle as acceptance: the new box loads and bb_valid stays 1, with no overrun.
- Only reset clears overrun and resync_count.
- Latency: from POLL_CHK seeing n>=3 to bb_valid rising is 7 cycles (3 reads x 2 cycles + PUBLISH).
- Reset mid-read: the word already popped by the slave is lost. flush_pending forces FLUSH on the next enable to discard the remainder.

Test Plan:
- reset, enable=1, slave FIFO empty -> one write of 0x10 to addr 0, then status reads spaced POLL_INTERVAL+2 cycles apart; bb_valid stays 0.
- queue {0x00524242, {5'b0,11'd100,5'b0,11'd50}, {5'b0,11'd200,5'b0,11'd120}} -> bb_valid rises 7 cycles after the status check with left=100, top=50, right=200, bottom=120, bb_none=0; m_read never high two cycles in a row.
- queue header plus TL=(639,479), BR=(0,0) -> bb_valid with bb_none=1 and raw edges passed through.
- queue stray word 0xDEADBEEF followed by a valid message -> resync_count=1, then the correct box is published.
- hold bb_ready=0 across two valid messages -> second box visible, bb_valid=1, overrun=1. Then bb_ready=1 for one cycle -> bb_valid=0 next cycle; overrun stays 1.
- assert reset between the header and TL reads, then enable -> all outputs 0, FLUSH write issued before the first poll, no partial box published.
